pipe_exc_ctrl: RTL
==================

# pipe_exc_ctrl

Parametrised pipeline exception and flush controller for the MIPS32 core: the next generation of the single-cycle syscall/eret control unit. It arbitrates hazard-unit stall/clear requests, commit-point exceptions (syscall, break, overflow, reserved instruction), `eret`, and maskable hardware interrupts. It produces per-stage write-enable/flush vectors, a PC redirect and CP0 update strobes. A small FSM holds the flush for a configurable number of cycles and counts taken exceptions.

## Interface
Parameters:
- `STAGES`, 5: number of pipeline register boundaries (PC, IF/ID, ID/EX, EX/MEM, MEM/WB); bit 0 is PC.
- `NIRQ`, 6: hardware interrupt lines (1..8), mapped to Status/Cause bits `[8 +: NIRQ]`.
- `FLUSH_CYCLES`, 1: extra cycles flush stays asserted after the detection cycle (0..15).
- `ADDR_W`, 32: PC width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; everything samples on rising edge.
- `rst` in 1: synchronous active-high reset.
- `stall_we` in STAGES: hazard-unit per-stage write enables.
- `stall_clr` in STAGES: hazard-unit per-stage clears.
- `commit_valid` in 1: MEM stage holds a real instruction.
- `exc_valid` in 1: synchronous exception raised by the MEM-stage instruction.
- `exc_code` in 5: ExcCode of that exception.
- `exc_eret` in 1: MEM-stage instruction is `eret`.
- `exc_delay` in 1: MEM-stage instruction sits in a branch delay slot.
- `exc_pc` in ADDR_W: PC of the MEM-stage instruction.
- `irq` in NIRQ: level-sensitive interrupt lines.
- `cp0_status`, `cp0_ebase`, `cp0_epc` in 32: CP0 register contents.
- `stage_we` out STAGES: per-stage write enables.
- `stage_flush` out STAGES: per-stage flushes.
- `redirect_valid` out 1: single-cycle PC-redirect strobe.
- `redirect_pc` out ADDR_W: redirect target.
- `cp0_we` out 1: write EPC/Cause/Status.EXL.
- `cp0_eret` out 1: clear Status.EXL.
- `cp0_epc_wdata` out ADDR_W: EPC value.
- `cp0_code` out 5: Cause.ExcCode.
- `cp0_bd` out 1: Cause.BD.
- `cp0_ip` out NIRQ: registered pending lines for Cause.IP.
- `busy` out 1: FSM not in IDLE.
- `exc_count` out 32: count of taken exceptions and interrupts, saturating.

## Operation
- `ip_q <= irq` every cycle. `cp0_ip = ip_q`.
- Event is taken only in IDLE. Priority: exception > eret > interrupt.
  - **Exception:** `exc_valid & commit_valid & ~Status[1]`.
  - **Eret:** `exc_eret & commit_valid`, taken regardless of EXL.
  - **Interrupt:** `commit_valid & Status[0] & ~Status[1] & |(ip_q & Status[8 +: NIRQ])`. Interrupt code is 0.
- **Detection cycle T (combinational outputs):**
  - `stage_flush` all ones, `stage_we` all ones, `redirect_valid` = 1.
  - Exception or interrupt: `cp0_we` = 1, `redirect_pc` = `cp0_ebase`, `cp0_epc_wdata` = `exc_pc - 4` if `exc_delay` else `exc_pc`, `cp0_bd` = `exc_delay`, `cp0_code` = the event's code.
  - Eret: `cp0_eret` = 1, `cp0_we` = 0, `redirect_pc` = `cp0_epc`.
  - Taken exception or interrupt increments `exc_count` (saturates at all ones; eret not counted).
  - Next state: FLUSH with count = FLUSH_CYCLES, or IDLE if FLUSH_CYCLES = 0.
- **FLUSH:** `stage_flush` and `stage_we` all ones; `redirect_valid`, `cp0_we`, `cp0_eret` = 0. All event inputs and hazard requests are ignored. Count decrements; returns to IDLE when count = 1.
- **IDLE, no event:** `stage_we` = `stall_we`, `stage_flush` = `stall_clr`, all strobes 0.
- An exception with EXL = 1 is ignored (pass-through). An interrupt with `commit_valid` = 0 is deferred; it is not lost while the level is held.

## Timing
- Reset values: state IDLE, `ip_q` 0, `exc_count` 0, `stage_we` and `stage_flush` all ones, all strobes 0, `redirect_pc` 0, `cp0_epc_wdata` 0, `busy` 0.
- Reset during FLUSH: IDLE on the next edge; no strobe is emitted during reset.
- Interrupt latency: an `irq` edge at cycle n is visible in `ip_q` at n+1; the interrupt is taken at the earliest at n+1.
- Back-to-back events: the earliest next event is taken at T+FLUSH_CYCLES+1.
- `redirect_valid`, `cp0_we` and `cp0_eret` are exactly one cycle wide per event.

## Structure
- `pipe_exc_pkg` holds:
  - ExcCode constants: INT=0, SYS=8, BP=9, RI=10, OV=12.
  - FSM state enum: IDLE, FLUSH.
  - Status bit indices: IE=0, EXL=1, IM base=8.
- One sub-module, `exc_prio_enc`: combinational priority select of event type and code.

## Test plan
- Reset, then idle with `stall_we`=5'b11011 and `stall_clr`=5'b00100 -> identical values on outputs; `busy`=0.
- Syscall (`exc_code`=8), `exc_pc`=0x80000010, `exc_delay`=1, EXL=0, `cp0_ebase`=0x80001000 -> at T: `cp0_we`=1, `cp0_epc_wdata`=0x8000000C, `cp0_bd`=1, `redirect_pc`=0x80001000, flush all ones. With FLUSH_CYCLES=2, `busy` for 2 cycles; `exc_count`=1.
- Eret with `cp0_epc`=0x00400020 -> `cp0_eret`=1, `cp0_we`=0, `redirect_pc`=0x00400020, `exc_count` unchanged.
- Same cycle: `exc_valid` (code 12) + `exc_eret` + unmasked irq -> only the overflow is taken, `cp0_code`=12. An `exc_valid` pulse during FLUSH -> ignored.
- `irq[2]`=1, Status=0x00000401 -> interrupt taken one cycle later with code 0. With Status IM2=0 or EXL=1 -> no action. With `commit_valid`=0 -> deferred until it returns to 1.
- `rst` asserted in the middle of FLUSH -> IDLE next cycle, flush/we all ones, `exc_count`=0.

Source files
------------

// File: rtl/pipe_exc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_exc_pkg
// Description : Shared constants and types for the pipeline exception control.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_exc_pkg;

    // Cause.ExcCode values
    localparam logic [4:0] c_EXC_INT = 5'd0;
    localparam logic [4:0] c_EXC_SYS = 5'd8;
    localparam logic [4:0] c_EXC_BP  = 5'd9;
    localparam logic [4:0] c_EXC_RI  = 5'd10;
    localparam logic [4:0] c_EXC_OV  = 5'd12;

    // Status register bit positions
    localparam int c_ST_IE      = 0;
    localparam int c_ST_EXL     = 1;
    localparam int c_ST_IM_BASE = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_EXC  = 2'd1,
        EVT_ERET = 2'd2,
        EVT_INT  = 2'd3
    } evt_t;

endpackage : pipe_exc_pkg
`default_nettype wire

// File: rtl/pipe_exc_ctrl_prio.sv
`default_nettype none
// ============================================================================
// Module      : exc_prio_enc
// Description : Selects the winning event (exception > eret > interrupt).
// Revision    : 1.0 - initial release
// ============================================================================
module exc_prio_enc
    import pipe_exc_pkg::*;
(
    input  logic       exc_hit,
    input  logic       eret_hit,
    input  logic       int_hit,
    input  logic [4:0] exc_code,
    output evt_t       evt,
    output logic [4:0] code
);

    always_comb begin
        evt  = EVT_NONE;
        code = c_EXC_INT;
        if (exc_hit) begin
            evt  = EVT_EXC;
            code = exc_code;
        end else if (eret_hit) begin
            evt  = EVT_ERET;
        end else if (int_hit) begin
            evt  = EVT_INT;
        end
    end

endmodule : exc_prio_enc
`default_nettype wire

// File: rtl/pipe_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_exc_ctrl
// Description : Pipeline exception/flush controller with PC redirect and CP0 strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_exc_ctrl
    import pipe_exc_pkg::*;
#(
    parameter int STAGES       = 5,
    parameter int NIRQ         = 6,
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_we,
    input  logic [STAGES-1:0] stall_clr,
    input  logic              commit_valid,
    input  logic              exc_valid,
    input  logic [4:0]        exc_code,
    input  logic              exc_eret,
    input  logic              exc_delay,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic [NIRQ-1:0]   irq,
    input  logic [31:0]       cp0_status,
    input  logic [31:0]       cp0_ebase,
    input  logic [31:0]       cp0_epc,
    output logic [STAGES-1:0] stage_we,
    output logic [STAGES-1:0] stage_flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              cp0_we,
    output logic              cp0_eret,
    output logic [ADDR_W-1:0] cp0_epc_wdata,
    output logic [4:0]        cp0_code,
    output logic              cp0_bd,
    output logic [NIRQ-1:0]   cp0_ip,
    output logic              busy,
    output logic [31:0]       exc_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [NIRQ-1:0]   r_ip;
    logic [31:0]       r_exc_count;
    logic              w_count_inc;

    logic              w_exl;
    logic              w_exc_hit;
    logic              w_eret_hit;
    logic              w_int_hit;
    evt_t              w_evt;
    logic [4:0]        w_code;
    logic              w_unused;

    assign w_exl      = cp0_status[c_ST_EXL];
    assign w_exc_hit  = exc_valid & commit_valid & ~w_exl;
    assign w_eret_hit = exc_eret & commit_valid;
    assign w_int_hit  = commit_valid & cp0_status[c_ST_IE] & ~w_exl
                      & (|(r_ip & cp0_status[c_ST_IM_BASE +: NIRQ]));

    // Status bits outside IE/EXL/IM carry no meaning for this block
    assign w_unused = ^{cp0_status[31:c_ST_IM_BASE+NIRQ], cp0_status[7:2]};

    exc_prio_enc u_prio (
        .exc_hit  (w_exc_hit),
        .eret_hit (w_eret_hit),
        .int_hit  (w_int_hit),
        .exc_code (exc_code),
        .evt      (w_evt),
        .code     (w_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_ip        <= '0;
            r_exc_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ip    <= irq;
            if (w_count_inc && !(&r_exc_count)) begin
                r_exc_count <= r_exc_count + 32'd1;
            end
        end
    end

    always_comb begin
        stage_we       = stall_we;
        stage_flush    = stall_clr;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cp0_we         = 1'b0;
        cp0_eret       = 1'b0;
        cp0_epc_wdata  = '0;
        cp0_code       = c_EXC_INT;
        cp0_bd         = 1'b0;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_count_inc    = 1'b0;

        if (rst) begin
            // Pipeline is held flushed while reset is applied; no strobes leak out
            stage_we    = '1;
            stage_flush = '1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_evt != EVT_NONE) begin
                        stage_we       = '1;
                        stage_flush    = '1;
                        redirect_valid = 1'b1;
                        if (w_evt == EVT_ERET) begin
                            cp0_eret    = 1'b1;
                            redirect_pc = ADDR_W'(cp0_epc);
                        end else begin
                            cp0_we        = 1'b1;
                            redirect_pc   = ADDR_W'(cp0_ebase);
                            cp0_epc_wdata = exc_delay ? (exc_pc - ADDR_W'(4)) : exc_pc;
                            cp0_bd        = exc_delay;
                            cp0_code      = w_code;
                            w_count_inc   = 1'b1;
                        end
                        if (FLUSH_CYCLES != 0) begin
                            w_state_nxt = ST_FLUSH;
                            w_cnt_nxt   = 4'(FLUSH_CYCLES);
                        end
                    end
                end
                ST_FLUSH: begin
                    stage_we    = '1;
                    stage_flush = '1;
                    w_cnt_nxt   = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign cp0_ip    = r_ip;
    assign busy      = ~rst & (r_state == ST_FLUSH);
    assign exc_count = r_exc_count;

endmodule : pipe_exc_ctrl
`default_nettype wire
